// File: rtl/y86_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   stat_t      : pipeline status codes carried alongside fetch/data results
//   INSTR_W     : width of one fetched instruction window (10 bytes)
package y86_mem_pkg;

    localparam int INSTR_W = 80;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_B0  = 3'd1,
        F_B1  = 3'd2,
        M_ACC = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus timeout counter for the memory port arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clr        : synchronous clear (state entry)
//   i_en         : count while a request is outstanding without ack
//   o_expired    : count has reached TIMEOUT-1
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at LAST so a stalled enable can never wrap back to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch
// (two-beat, any byte alignment) and the memory stage (single beat R/W).
//   clk, reset_n          : clock, asynchronous active-low reset
//   f_req/f_addr          : fetch request, held until f_valid
//   f_valid/f_instr/f_err : fetch result pulse, 10 bytes from f_addr
//   m_req/m_write/m_addr/m_wdata : data access, held until m_valid
//   m_valid/m_rdata/m_err : data result pulse
//   f_stall_req/m_stall_req : combinational stall requests to hazard control
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, stable until mem_ack
//   mem_ack/mem_rdata/mem_err : memory completion
//
// state | meaning
// IDLE  | no transaction; data request beats fetch
// F_B0  | fetch beat 0 (aligned base) outstanding
// F_B1  | fetch beat 1 (base + 8) outstanding
// M_ACC | data access outstanding
// DONE  | result valid pulse; always returns to IDLE
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    output logic               f_valid,
    output logic [INSTR_W-1:0] f_instr,
    output logic               f_err,
    input  logic               m_req,
    input  logic               m_write,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    output logic               m_valid,
    output logic [DATA_W-1:0]  m_rdata,
    output logic               m_err,
    output logic               f_stall_req,
    output logic               m_stall_req,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       w_done_err;

    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [ADDR_W-1:0]  r_f_addr;
    logic [DATA_W-1:0]  r_beat0;

    logic               r_f_valid;
    logic [INSTR_W-1:0] r_f_instr;
    logic               r_f_err;
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_rdata;
    logic               r_m_err;

    logic               w_ack;
    logic               w_expired;
    logic               w_timeout;
    logic               w_wrap;
    logic [5:0]         w_shift;
    logic [INSTR_W-1:0] w_instr;

    // An ack with no request outstanding is ignored.
    assign w_ack     = mem_ack & r_mem_req;
    assign w_timeout = r_mem_req & ~mem_ack & w_expired;

    // Beat 1 would wrap past the top of the address space.
    assign w_wrap  = &r_f_addr[ADDR_W-1:3];
    assign w_shift = {r_f_addr[2:0], 3'b000};
    assign w_instr = INSTR_W'({mem_rdata, r_beat0} >> w_shift);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_state_nxt != r_state),
        .i_en      (r_mem_req & ~mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Data access belongs to the older instruction, so it wins.
                if (m_req) begin
                    w_state_nxt = M_ACC;
                end else if (f_req) begin
                    w_state_nxt = F_B0;
                end
            end
            F_B0: begin
                if (w_ack) begin
                    if (mem_err || w_wrap) begin
                        w_state_nxt = DONE;
                        w_done_err  = 1'b1;
                    end else begin
                        w_state_nxt = F_B1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end
            end
            F_B1, M_ACC: begin
                if (w_ack) begin
                    w_state_nxt = DONE;
                    w_done_err  = mem_err;
                end else if (w_timeout) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_addr    <= '0;
            r_beat0     <= '0;
        end else if ((r_state == IDLE) && (w_state_nxt == M_ACC)) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= m_write;
            r_mem_addr  <= m_addr;
            r_mem_wdata <= m_wdata;
        end else if ((r_state == IDLE) && (w_state_nxt == F_B0)) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {f_addr[ADDR_W-1:3], 3'b000};
            r_f_addr   <= f_addr;
        end else if ((r_state == F_B0) && (w_state_nxt == F_B1)) begin
            r_beat0    <= mem_rdata;
            r_mem_addr <= r_mem_addr + ADDR_W'(8);
        end else if (w_state_nxt == DONE) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    // Result registers; valid is high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_valid <= 1'b0;
            r_f_instr <= '0;
            r_f_err   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_rdata <= '0;
            r_m_err   <= 1'b0;
        end else begin
            r_f_valid <= 1'b0;
            r_m_valid <= 1'b0;
            if (w_state_nxt == DONE) begin
                if (r_state == M_ACC) begin
                    r_m_valid <= 1'b1;
                    r_m_err   <= w_done_err;
                    r_m_rdata <= (w_done_err || r_mem_we) ? '0 : mem_rdata;
                end else begin
                    r_f_valid <= 1'b1;
                    r_f_err   <= w_done_err;
                    r_f_instr <= w_done_err ? '0 : w_instr;
                end
            end
        end
    end

    assign f_valid     = r_f_valid;
    assign f_instr     = r_f_instr;
    assign f_err       = r_f_err;
    assign m_valid     = r_m_valid;
    assign m_rdata     = r_m_rdata;
    assign m_err       = r_m_err;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign f_stall_req = f_req & ~r_f_valid;
    assign m_stall_req = m_req & ~r_m_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import y86_mem_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 16;

    logic               clk;
    logic               reset_n;
    logic               f_req;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_valid;
    logic [INSTR_W-1:0] f_instr;
    logic               f_err;
    logic               m_req;
    logic               m_write;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic               m_valid;
    logic [DATA_W-1:0]  m_rdata;
    logic               m_err;
    logic               f_stall_req;
    logic               m_stall_req;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ack;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_err;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_valid     (f_valid),
        .f_instr     (f_instr),
        .f_err       (f_err),
        .m_req       (m_req),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_valid     (m_valid),
        .m_rdata     (m_rdata),
        .m_err       (m_err),
        .f_stall_req (f_stall_req),
        .m_stall_req (m_stall_req),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: byte at address a holds a[7:0]; zero-wait when mem_en.
    logic              mem_en;
    logic [ADDR_W-1:0] err_addr;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;

    assign mem_ack = mem_req & mem_en;
    assign mem_err = mem_ack & (mem_addr == err_addr);

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = 8'(mem_addr + 64'(k));
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    function automatic logic [79:0] exp_instr(input logic [63:0] a);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[8*k +: 8] = 8'(a + 64'(k));
        return r;
    endfunction

    function automatic logic [63:0] exp_beat(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(a + 64'(k));
        return r;
    endfunction

    typedef struct { logic [79:0] instr; logic err; bit chk; } f_exp_t;
    typedef struct { logic [63:0] data; logic err; } m_exp_t;
    f_exp_t f_q[$];
    m_exp_t m_q[$];

    int n_checks;
    int n_errors;

    // Observation record filled by run_window.
    int          obs_f_cyc, obs_m_cyc, obs_f_cnt, obs_m_cnt, obs_req_cyc, obs_rd_first;
    logic [79:0] obs_f_instr;
    logic        obs_f_err;
    logic [63:0] obs_m_rdata;
    logic        obs_m_err;
    bit          obs_stall_bad;
    logic [63:0] obs_addrs[$];

    task automatic run_window(input int budget, input int min_cyc, input bit want_f, input bit want_m);
        obs_f_cyc = -1; obs_m_cyc = -1; obs_f_cnt = 0; obs_m_cnt = 0;
        obs_req_cyc = 0; obs_rd_first = -1; obs_stall_bad = 1'b0;
        obs_f_instr = '0; obs_f_err = 1'b0; obs_m_rdata = '0; obs_m_err = 1'b0;
        obs_addrs.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (mem_req) begin
                obs_req_cyc++;
                obs_addrs.push_back(mem_addr);
                if (!mem_we && obs_rd_first < 0) obs_rd_first = c;
            end
            if (f_stall_req !== (f_req & ~f_valid) || m_stall_req !== (m_req & ~m_valid)) obs_stall_bad = 1'b1;
            if (f_valid) begin
                obs_f_cnt++;
                if (obs_f_cyc < 0) begin obs_f_cyc = c; obs_f_instr = f_instr; obs_f_err = f_err; end
                f_req = 1'b0;
            end
            if (m_valid) begin
                obs_m_cnt++;
                if (obs_m_cyc < 0) begin obs_m_cyc = c; obs_m_rdata = m_rdata; obs_m_err = m_err; end
                m_req = 1'b0;
            end
            if (c >= min_cyc && (!want_f || obs_f_cyc >= 0) && (!want_m || obs_m_cyc >= 0)) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({f_valid, f_err, m_valid, m_err, mem_req, mem_we, f_stall_req, m_stall_req} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_flags: got %b, required 00000000", {f_valid, f_err, m_valid, m_err, mem_req, mem_we, f_stall_req, m_stall_req});
        end
        n_checks++;
        if (f_instr !== '0 || m_rdata !== '0) begin
            n_errors++; $display("FAIL reset_data: f_instr=%h m_rdata=%h, required 0", f_instr, m_rdata);
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_errors++; $display("FAIL reset_mem: mem_addr=%h mem_wdata=%h, required 0", mem_addr, mem_wdata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch_offset();
        f_exp_t fe;
        f_addr = 64'h103; f_req = 1'b1;
        f_q.push_back('{exp_instr(64'h103), 1'b0, 1'b1});
        run_window(20, 1, 1'b1, 1'b0);
        n_checks++;
        if (obs_f_cyc != 3) begin n_errors++; $display("FAIL fetch_latency: got %0d, required 3", obs_f_cyc); end
        n_checks++;
        if (obs_addrs.size() != 2 || obs_addrs[0] !== 64'h100 || obs_addrs[obs_addrs.size()-1] !== 64'h108) begin
            n_errors++; $display("FAIL fetch_beats: %0d beats, first=%h last=%h, required 2 beats 100 then 108",
                                 obs_addrs.size(), obs_addrs[0], obs_addrs[obs_addrs.size()-1]);
        end
        n_checks++;
        if (obs_stall_bad) begin n_errors++; $display("FAIL fetch_stall: stall_req differed from req & ~valid, required equal"); end
        fe = f_q.pop_front();
        n_checks++;
        if (obs_f_cyc < 0 || obs_f_err !== fe.err || obs_f_instr !== fe.instr) begin
            n_errors++; $display("FAIL fetch_result: instr=%h err=%b, required instr=%h err=%b", obs_f_instr, obs_f_err, fe.instr, fe.err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        f_exp_t fe;
        m_exp_t me;
        int wr0;
        wr0 = wr_cnt;
        f_addr = 64'h10; f_req = 1'b1;
        m_addr = 64'h200; m_write = 1'b1; m_wdata = 64'hDEAD; m_req = 1'b1;
        f_q.push_back('{exp_instr(64'h10), 1'b0, 1'b1});
        m_q.push_back('{64'h0, 1'b0});
        run_window(40, 1, 1'b1, 1'b1);
        n_checks++;
        if (obs_m_cyc != 2) begin n_errors++; $display("FAIL prio_m_latency: got %0d, required 2", obs_m_cyc); end
        n_checks++;
        if (obs_rd_first != 4) begin n_errors++; $display("FAIL prio_fetch_start: got %0d, required 4", obs_rd_first); end
        n_checks++;
        if (obs_f_cyc != 6) begin n_errors++; $display("FAIL prio_f_latency: got %0d, required 6", obs_f_cyc); end
        n_checks++;
        if (wr_cnt != wr0 + 1 || wr_addr !== 64'h200 || wr_data !== 64'hDEAD) begin
            n_errors++; $display("FAIL prio_write: count=%0d addr=%h data=%h, required 1 at 200 data dead", wr_cnt - wr0, wr_addr, wr_data);
        end
        me = m_q.pop_front();
        n_checks++;
        if (obs_m_cyc < 0 || obs_m_rdata !== me.data || obs_m_err !== me.err) begin
            n_errors++; $display("FAIL prio_m_result: rdata=%h err=%b, required rdata=%h err=%b", obs_m_rdata, obs_m_err, me.data, me.err);
        end
        fe = f_q.pop_front();
        n_checks++;
        if (obs_f_cyc < 0 || obs_f_err !== fe.err || obs_f_instr !== fe.instr) begin
            n_errors++; $display("FAIL prio_f_result: instr=%h err=%b, required instr=%h err=%b", obs_f_instr, obs_f_err, fe.instr, fe.err);
        end
        m_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_m_during_fetch();
        f_exp_t fe;
        m_exp_t me;
        f_addr = 64'h20; f_req = 1'b1;
        f_q.push_back('{exp_instr(64'h20), 1'b0, 1'b1});
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h20) begin
            n_errors++; $display("FAIL mdf_beat0: mem_req=%b mem_addr=%h, required 1 and 20", mem_req, mem_addr);
        end
        m_addr = 64'h300; m_write = 1'b0; m_req = 1'b1;
        m_q.push_back('{exp_beat(64'h300), 1'b0});
        run_window(40, 1, 1'b1, 1'b1);
        n_checks++;
        if (obs_f_cyc != 2 || obs_m_cyc != 5) begin
            n_errors++; $display("FAIL mdf_order: f at %0d m at %0d, required f at 2 m at 5", obs_f_cyc, obs_m_cyc);
        end
        n_checks++;
        if (obs_addrs.size() != 2 || obs_addrs[0] !== 64'h28 || obs_addrs[obs_addrs.size()-1] !== 64'h300) begin
            n_errors++; $display("FAIL mdf_addrs: %0d reqs first=%h last=%h, required 28 then 300",
                                 obs_addrs.size(), obs_addrs[0], obs_addrs[obs_addrs.size()-1]);
        end
        n_checks++;
        if (obs_stall_bad) begin n_errors++; $display("FAIL mdf_stall: stall_req differed from req & ~valid, required equal"); end
        fe = f_q.pop_front();
        n_checks++;
        if (obs_f_cyc < 0 || obs_f_err !== fe.err || obs_f_instr !== fe.instr) begin
            n_errors++; $display("FAIL mdf_f_result: instr=%h err=%b, required instr=%h err=%b", obs_f_instr, obs_f_err, fe.instr, fe.err);
        end
        me = m_q.pop_front();
        n_checks++;
        if (obs_m_cyc < 0 || obs_m_rdata !== me.data || obs_m_err !== me.err) begin
            n_errors++; $display("FAIL mdf_m_result: rdata=%h err=%b, required rdata=%h err=%b", obs_m_rdata, obs_m_err, me.data, me.err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        m_exp_t me;
        int v_cnt, cyc1, cyc2;
        v_cnt = 0; cyc1 = -1; cyc2 = -1;
        m_write = 1'b0; m_addr = 64'h88; m_req = 1'b1;
        m_q.push_back('{exp_beat(64'h88), 1'b0});
        for (int c = 1; c <= 20 && v_cnt < 2; c++) begin
            @(negedge clk);
            if (m_valid) begin
                v_cnt++;
                me = m_q.pop_front();
                n_checks++;
                if (m_rdata !== me.data || m_err !== me.err) begin
                    n_errors++; $display("FAIL b2b_result%0d: rdata=%h err=%b, required rdata=%h err=%b", v_cnt, m_rdata, m_err, me.data, me.err);
                end
                if (v_cnt == 1) begin
                    cyc1 = c;
                    m_addr = 64'h90;
                    m_q.push_back('{exp_beat(64'h90), 1'b0});
                end else begin
                    cyc2 = c;
                    m_req = 1'b0;
                end
            end
        end
        m_req = 1'b0;
        n_checks++;
        if (cyc1 != 2 || cyc2 != 5) begin
            n_errors++; $display("FAIL b2b_spacing: valids at %0d and %0d, required 2 and 5", cyc1, cyc2);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        m_exp_t me;
        mem_en = 1'b0;
        m_addr = 64'h40; m_write = 1'b0; m_req = 1'b1;
        m_q.push_back('{64'h0, 1'b1});
        run_window(60, 1, 1'b0, 1'b1);
        mem_en = 1'b1;
        n_checks++;
        if (obs_req_cyc != TIMEOUT) begin n_errors++; $display("FAIL timeout_req_len: got %0d, required %0d", obs_req_cyc, TIMEOUT); end
        n_checks++;
        if (obs_m_cyc != TIMEOUT + 1) begin n_errors++; $display("FAIL timeout_valid: got %0d, required %0d", obs_m_cyc, TIMEOUT + 1); end
        me = m_q.pop_front();
        n_checks++;
        if (obs_m_cyc < 0 || obs_m_rdata !== me.data || obs_m_err !== me.err) begin
            n_errors++; $display("FAIL timeout_result: rdata=%h err=%b, required rdata=%h err=%b", obs_m_rdata, obs_m_err, me.data, me.err);
        end
        repeat (2) @(negedge clk);
    endtask

    // Fetches that end after beat 0: address wrap and bus error.
    task automatic test_fetch_error();
        logic [63:0] addr_t [2] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h61};
        logic [63:0] err_t  [2] = '{64'h1, 64'h60};
        logic [63:0] beat_t [2] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h60};
        f_exp_t fe;
        for (int i = 0; i < 2; i++) begin
            err_addr = err_t[i];
            f_addr = addr_t[i]; f_req = 1'b1;
            f_q.push_back('{80'h0, 1'b1, 1'b0});
            run_window(30, 8, 1'b1, 1'b0);
            err_addr = 64'h1;
            n_checks++;
            if (obs_f_cyc != 2) begin n_errors++; $display("FAIL ferr%0d_latency: got %0d, required 2", i, obs_f_cyc); end
            n_checks++;
            if (obs_req_cyc != 1 || obs_addrs[0] !== beat_t[i]) begin
                n_errors++; $display("FAIL ferr%0d_beats: %0d req cycles first=%h, required 1 at %h", i, obs_req_cyc, obs_addrs[0], beat_t[i]);
            end
            fe = f_q.pop_front();
            n_checks++;
            if (obs_f_cnt != 1 || obs_f_err !== fe.err) begin
                n_errors++; $display("FAIL ferr%0d_result: pulses=%0d err=%b, required 1 pulse err=%b", i, obs_f_cnt, obs_f_err, fe.err);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_fetch();
        f_exp_t fe;
        f_addr = 64'h50; f_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h58) begin
            n_errors++; $display("FAIL rst_in_fb1: mem_req=%b mem_addr=%h, required 1 and 58", mem_req, mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_async_req: mem_req=%b, required 0", mem_req); end
        f_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_window(8, 8, 1'b0, 1'b0);
        n_checks++;
        if (obs_f_cnt != 0 || obs_req_cyc != 0) begin
            n_errors++; $display("FAIL rst_discard: f_valid pulses=%0d req cycles=%0d, required 0 and 0", obs_f_cnt, obs_req_cyc);
        end
        f_addr = 64'h58; f_req = 1'b1;
        f_q.push_back('{exp_instr(64'h58), 1'b0, 1'b1});
        run_window(20, 1, 1'b1, 1'b0);
        n_checks++;
        if (obs_f_cyc != 3 || obs_addrs.size() != 2 || obs_addrs[0] !== 64'h58) begin
            n_errors++; $display("FAIL rst_restart: valid at %0d, %0d beats first=%h, required 3, 2 beats from 58",
                                 obs_f_cyc, obs_addrs.size(), obs_addrs[0]);
        end
        fe = f_q.pop_front();
        n_checks++;
        if (obs_f_cyc < 0 || obs_f_err !== fe.err || obs_f_instr !== fe.instr) begin
            n_errors++; $display("FAIL rst_restart_result: instr=%h err=%b, required instr=%h err=%b", obs_f_instr, obs_f_err, fe.instr, fe.err);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0;
        f_req = 1'b0; f_addr = '0;
        m_req = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        mem_en = 1'b1; err_addr = 64'h1;
        test_reset();
        test_fetch_offset();
        test_priority();
        test_m_during_fetch();
        test_back_to_back();
        test_timeout();
        test_fetch_error();
        test_reset_mid_fetch();
        n_checks++;
        if (f_q.size() != 0 || m_q.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_drain: f left=%0d m left=%0d, required 0 and 0", f_q.size(), m_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
